bk_add_arbiter: RTL
===================

Name: bk_add_arbiter

Overview:
- Shares one combinational 12-bit Brent-Kung adder core (24 interleaved inputs, 13-bit sum with carry-out) among NREQ independent requesters.
- Round-robin arbitration, valid/ready handshake on every requester and on the single response port, one registered result stage.
- Sits between the DSP request ports and the shared adder. It is the only block that drives the adder's inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operation valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_a  in  12*NREQ  operand A; requester i uses bits [12i+11:12i]
- req_b  in  12*NREQ  operand B; same packing as req_a
- rsp_valid  out  1  result register holds a valid result
- rsp_ready  in  1  consumer accepts the result
- rsp_sum  out  13  {carry, sum[11:0]} = A + B
- rsp_id  out  IDW  index of the requester that issued the result
- busy  out  1  high when rsp_valid is high or any req_valid bit is high

Behaviour:
- Adder mapping: core input 2k = A[k], core input 2k+1 = B[k], k = 0..11. Core output k = sum[k]; output 12 = carry. No carry-in.
- Output stage FSM, two states:
  - EMPTY: rsp_valid = 0.
  - FULL: rsp_valid = 1.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on rsp_ready with no accept.
  - FULL -> FULL on rsp_ready with a simultaneous accept: the register is overwritten with the new result, giving back-to-back throughput of 1 op/cycle.
  - FULL with rsp_ready low: hold; rsp_sum and rsp_id stay stable.
- can_accept = (state == EMPTY) | rsp_ready.
- Arbitration: round-robin pointer ptr (0..NREQ-1).
  - Grant goes to the first i with req_valid[i] = 1, searching ptr, ptr+1, ... with modulo NREQ wrap-around.
  - req_ready[g] = can_accept & req_valid[g]; all other req_ready bits are 0.
  - Grant is computed combinationally each cycle. The grant may change while a requester is stalled; the requester must hold its request until it sees ready.
- On accept (req_valid[g] & req_ready[g]):
  - rsp_sum <= A_g + B_g (13-bit) and rsp_id <= g on the next clock edge.
  - ptr <= (g + 1) mod NREQ.
- Without an accept, ptr holds its value.
- Latency: a result is visible on rsp_* exactly one cycle after the accept edge.
- Fairness: under continuous requests from all requesters with rsp_ready held high, each requester is granted once every NREQ cycles.
- Reset (asynchronous, any time, including mid-stall):
  - state = EMPTY, ptr = 0.
  - rsp_valid = 0, rsp_sum = 0, rsp_id = 0.
  - req_ready = 0 while rst_n is low.
  - Any held result is discarded.
- Outputs are glitch-free registers, except req_ready and busy, which are combinational.

Optional Feature:
- Macro: BK_ADD_ARB_STATS_EN.
- When defined, adds the following ports:
  - stat_ops out 16: count of accepted operations, saturating at 0xFFFF.
  - stat_stall out 16: count of cycles with state == FULL & ~rsp_ready, saturating.
  - stat_clr in 1: synchronous clear of both counters. When stat_clr and an increment occur in the same cycle, the clear wins.
- Both counters reset to 0 on rst_n low.
- When the macro is undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset check: assert rst_n = 0 mid-transfer with rsp_valid = 1 and rsp_ready = 0. Required: rsp_valid = 0, rsp_sum = 0, req_ready = 0 immediately, and after release the first grant goes to requester 0.
- Single op with carry: req 2 sends A = 0xFFF, B = 0x001 with rsp_ready = 1. Required: req_ready = 0b0100 in the accept cycle; next cycle rsp_valid = 1, rsp_sum = 0x1000, rsp_id = 2.
- Round robin: all 4 requesters continuously valid with A = i, B = 0x100, rsp_ready = 1. Required: rsp_id sequence 0,1,2,3,0,...; rsp_sum = 0x100 + id; one result per cycle.
- Backpressure: rsp_ready = 0 for 5 cycles after the first result, with req 1 valid at A = 0x800, B = 0x800. Required: held result stable, req_ready = 0. Once rsp_ready rises, in that same cycle req 1 is accepted; next cycle rsp_sum = 0x1000, rsp_id = 1.
- Wrap-around and sparse requests: ptr = 3, only req 1 and req 3 valid. Required: grant order 3, 1, 3, 1. Zero operands A = B = 0 give rsp_sum = 0.
- With BK_ADD_ARB_STATS_EN defined: run 10 accepts and 5 stall cycles. Required: stat_ops = 10, stat_stall = 5. Pulse stat_clr: both counters read 0 the next cycle. Preload stat_ops near 0xFFFF and continue accepting: it saturates at 0xFFFF.

Source files
------------

// File: rtl/bk_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bk_add_arbiter
//  Description : Round-robin front end for a shared 12-bit Brent-Kung adder.
//                NREQ requesters present A/B operands with valid/ready. One
//                of them is granted per cycle. Its sum and requester index
//                are captured in a single result register, which is drained
//                through a valid/ready response port.
//
//  Ports       : clk        rising-edge clock
//                rst_n      asynchronous active-low reset
//                req_valid  [NREQ]     per-requester operation valid
//                req_ready  [NREQ]     per-requester accept (one-hot or zero)
//                req_a      [12*NREQ]  operand A, requester i at [12i+11:12i]
//                req_b      [12*NREQ]  operand B, same packing
//                rsp_valid  result register holds a valid result
//                rsp_ready  consumer accepts the result
//                rsp_sum    [13]  {carry, sum[11:0]}
//                rsp_id     [IDW] index of the issuing requester
//                busy       result pending or any request pending
//
//  Optional    : `define BK_ADD_ARB_STATS_EN adds the following ports:
//                stat_ops   [16] accepted operations (saturating)
//                stat_stall [16] cycles with a result held and rsp_ready low
//                                (saturating)
//                stat_clr        synchronous clear; it wins over increments
//
//  Revision    : 1.0  initial release
// ============================================================================
module bk_add_arbiter #(
    parameter int NREQ = 4,   // 2..8
    parameter int IDW  = 2    // 2**IDW must be >= NREQ
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [12*NREQ-1:0]   req_a,
    input  logic [12*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [12:0]          rsp_sum,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
`ifdef BK_ADD_ARB_STATS_EN
    ,
    output logic [15:0]          stat_ops,
    output logic [15:0]          stat_stall,
    input  logic                 stat_clr
`endif
);

    localparam int c_W = 12;

    // ------------------------------------------------------------------
    // Brent-Kung adder core. The 12 bit positions are padded to 16 so
    // the up-sweep / down-sweep strides are plain powers of two. The
    // padded positions carry g = p = 0 and never reach the outputs.
    // Input 2k is A[k], input 2k+1 is B[k]. Output k is sum[k] and
    // output 12 is the carry-out.
    // ------------------------------------------------------------------
    function automatic logic [c_W:0] bk_core(input logic [2*c_W-1:0] ilv);
        logic [15:0]  g;
        logic [15:0]  p;
        logic [15:0]  p_bit;
        logic [c_W:0] res;
        g     = '0;
        p     = '0;
        res   = '0;
        for (int k = 0; k < c_W; k++) begin
            g[k] = ilv[2*k] & ilv[2*k+1];
            p[k] = ilv[2*k] ^ ilv[2*k+1];
        end
        p_bit = p;
        // Up-sweep: after this, the group (g,p) at indices 2^n-1 covers [0..i].
        for (int d = 1; d < 16; d = d * 2) begin
            for (int i = 2*d - 1; i < 16; i = i + 2*d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        // Down-sweep: fill in the remaining prefixes from the spine.
        for (int d = 4; d >= 1; d = d / 2) begin
            for (int i = 3*d - 1; i < 16; i = i + 2*d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        res[0] = p_bit[0];
        for (int k = 1; k < c_W; k++) begin
            res[k] = p_bit[k] ^ g[k-1];
        end
        res[c_W] = g[c_W-1];
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Output stage state
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [12:0]      r_sum;
    logic [IDW-1:0]   r_id;

    logic [IDW-1:0]   w_gnt;
    logic             w_gnt_found;
    logic             w_can_accept;
    logic             w_accept;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [c_W-1:0]   w_op_a;
    logic [c_W-1:0]   w_op_b;
    logic [2*c_W-1:0] w_core_in;
    logic [c_W:0]     w_core_out;

    // ------------------------------------------------------------------
    // Round-robin search starting at r_ptr, wrapping modulo NREQ.
    // ------------------------------------------------------------------
    always_comb begin
        int w_idx;
        w_idx       = 0;
        w_gnt       = '0;
        w_gnt_found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            w_idx = int'(r_ptr) + j;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_gnt_found && req_valid[w_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt       = IDW'(w_idx);
            end
        end
    end

    // The result register can take a new value when it is empty or is
    // being drained in this same cycle. Gating with rst_n keeps every
    // ready low while reset is asserted.
    assign w_can_accept = (r_state == ST_EMPTY) | rsp_ready;
    assign w_accept     = rst_n & w_can_accept & w_gnt_found;
    assign w_ptr_nxt    = (w_gnt == IDW'(NREQ-1)) ? '0 : (w_gnt + 1'b1);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_accept & (w_gnt == IDW'(i));
        end
    end

    // Operand mux feeding the shared core
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt == IDW'(i)) begin
                w_op_a = req_a[c_W*i +: c_W];
                w_op_b = req_b[c_W*i +: c_W];
            end
        end
    end

    generate
        for (genvar k = 0; k < c_W; k++) begin : g_ilv
            assign w_core_in[2*k]   = w_op_a[k];
            assign w_core_in[2*k+1] = w_op_b[k];
        end
    endgenerate

    assign w_core_out = bk_core(w_core_in);

    // ------------------------------------------------------------------
    // Output stage FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                // An accept in the same cycle as the drain overwrites
                // the register, so the stage stays FULL.
                if (rsp_ready && !w_accept) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Result register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_id  <= '0;
            r_ptr <= '0;
        end else if (w_accept) begin
            r_sum <= w_core_out;
            r_id  <= w_gnt;
            r_ptr <= w_ptr_nxt;
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_sum   = r_sum;
    assign rsp_id    = r_id;
    assign busy      = rsp_valid | (|req_valid);

`ifdef BK_ADD_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating activity counters
    // ------------------------------------------------------------------
    logic [15:0] r_stat_ops;
    logic [15:0] r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ops   <= '0;
            r_stat_stall <= '0;
        end else if (stat_clr) begin
            r_stat_ops   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_accept && (r_stat_ops != 16'hFFFF)) begin
                r_stat_ops <= r_stat_ops + 16'd1;
            end
            if ((r_state == ST_FULL) && !rsp_ready && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    assign stat_ops   = r_stat_ops;
    assign stat_stall = r_stat_stall;
`endif

endmodule
`default_nettype wire
